// File: rtl/class_tree_arb.sv
// class_tree_arb
//   Round-robin front end that lets N_REQ requesters share one combinational
//   classifier. A granted feature vector is registered onto cls_feat. One
//   cycle later the classifier output is captured and returned to the owner
//   with a valid/ready handshake. Two saturating counters track completed
//   classifications and positive results.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid              [N_REQ]
//   req_feat   packed feature vectors, k at [k*FEAT_W +: FEAT_W]
//   req_ready  one-hot grant strobe, only ever high in IDLE [N_REQ]
//   cls_feat   registered vector driving the classifier [FEAT_W]
//   cls_o      classifier result for cls_feat
//   rsp_valid  result valid
//   rsp_ready  result consumer ready
//   rsp_id     requester that owns the result
//   rsp_class  captured classification
//   total_cnt  completed classifications (saturating)  [CNT_W]
//   pos_cnt    completed positive results (saturating) [CNT_W]
//   clr_cnt    synchronous clear of both counters
module class_tree_arb #(
    parameter int N_REQ  = 4,
    parameter int FEAT_W = 51,
    parameter int CNT_W  = 16,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FEAT_W-1:0] req_feat,
    output logic [N_REQ-1:0]        req_ready,
    output logic [FEAT_W-1:0]       cls_feat,
    input  logic                    cls_o,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_class,
    output logic [CNT_W-1:0]        total_cnt,
    output logic [CNT_W-1:0]        pos_cnt,
    input  logic                    clr_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    localparam logic [ID_W:0] N_EXT = (ID_W + 1)'(N_REQ);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [N_REQ-1:0]    rotated;
    logic                grant_found;
    logic [ID_W-1:0]     grant_off;
    logic [ID_W:0]       grant_sum;
    logic [ID_W-1:0]     grant_idx;
    logic [FEAT_W-1:0]   sel_feat;
    logic                handshake;

    // Rotate the request vector so that bit 0 is the requester at rr_ptr;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    assign rotated = N_REQ'({req_valid, req_valid} >> rr_ptr);

    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        grant_found = 1'b0;
        grant_off   = '0;
        // Descending scan so the lowest set offset is the last one written.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                grant_found = 1'b1;
                grant_off   = ID_W'(j);
            end
        end
    end

    // Map the rotated offset back to an absolute index, wrapping at N_REQ.
    always_comb begin
        grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        if (grant_sum >= N_EXT) begin
            grant_idx = ID_W'(grant_sum - N_EXT);
        end else begin
            grant_idx = ID_W'(grant_sum);
        end
    end

    always_comb begin
        sel_feat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_feat = req_feat[k*FEAT_W +: FEAT_W];
            end
        end
    end

    // The grant strobe is combinational so a requester sees acceptance in the
    // same cycle; it is suppressed while reset is asserted.
    assign req_ready = (!rst && state == IDLE && grant_found)
                     ? (N_REQ'(1) << grant_idx) : '0;

    assign handshake = (state == RESP) && rsp_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cls_feat  <= '0;
            rsp_id    <= '0;
            rsp_class <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cls_feat <= sel_feat;
                        rsp_id   <= grant_idx;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    // cls_feat has been stable for a full cycle here.
                    rsp_class <= cls_o;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        rr_ptr    <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics: clear takes priority over a coincident handshake; each
    // counter sticks at all-ones independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cnt <= '0;
            pos_cnt   <= '0;
        end else if (clr_cnt) begin
            total_cnt <= '0;
            pos_cnt   <= '0;
        end else if (handshake) begin
            if (total_cnt != '1) begin
                total_cnt <= total_cnt + CNT_W'(1);
            end
            if (rsp_class && pos_cnt != '1) begin
                pos_cnt <= pos_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_class_tree_arb.sv
// tb_class_tree_arb
//   Directed bench for class_tree_arb. The classifier is modelled as
//   cls_o = cls_feat[0], so the expected class of each stored feature vector
//   is its bit 0, tabulated by hand in exp_cls. Inputs change and outputs are
//   sampled 1 time unit after the falling clock edge.
module tb_class_tree_arb;

    localparam int N_REQ  = 4;
    localparam int FEAT_W = 51;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*FEAT_W-1:0] req_feat;
    logic [N_REQ-1:0]        req_ready;
    logic [FEAT_W-1:0]       cls_feat;
    logic                    cls_o;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic                    rsp_class;
    logic [CNT_W-1:0]        total_cnt;
    logic [CNT_W-1:0]        pos_cnt;
    logic                    clr_cnt;

    logic [FEAT_W-1:0] feat_tb [N_REQ];
    // Bit 0 of feat_tb[0..3] as initialised below: ...C, ...1, ...E, ...3.
    logic exp_cls [N_REQ] = '{1'b0, 1'b1, 1'b0, 1'b1};

    int n_tests = 0;
    int n_fail  = 0;

    class_tree_arb #(
        .N_REQ (N_REQ),
        .FEAT_W(FEAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_feat (req_feat),
        .req_ready(req_ready),
        .cls_feat (cls_feat),
        .cls_o    (cls_o),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_class(rsp_class),
        .total_cnt(total_cnt),
        .pos_cnt  (pos_cnt),
        .clr_cnt  (clr_cnt)
    );

    assign cls_o = cls_feat[0];

    always_comb begin
        req_feat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_feat[k*FEAT_W +: FEAT_W] = feat_tb[k];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Entered in an IDLE cycle with the request already presented; leaves the
    // bench in the RESP cycle of that transaction.
    task automatic run_txn(input int id, input logic cls);
        logic [N_REQ-1:0] oh;
        oh = N_REQ'(1) << id;
        check($sformatf("grant id%0d", id), req_ready, oh);
        step();
        check("eval ready", req_ready, 0);
        check("eval rsp_valid", rsp_valid, 0);
        step();
        check("resp valid", rsp_valid, 1);
        check($sformatf("resp id%0d", id), rsp_id, id);
        check($sformatf("resp class id%0d", id), rsp_class, cls);
        check($sformatf("resp feat id%0d", id), cls_feat, feat_tb[id]);
    endtask

    initial begin
        feat_tb[0] = 51'h1_2345_6789_ABCC;
        feat_tb[1] = 51'h2_468A_CE02_4681;
        feat_tb[2] = 51'h7_0F0F_0F0F_0F0E;
        feat_tb[3] = 51'h5_5555_AAAA_3333;
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        clr_cnt   = 1'b0;

        // Reset state, with requests pending to show the grant is suppressed.
        step();
        step();
        check("rst req_ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_id", rsp_id, 0);
        check("rst rsp_class", rsp_class, 0);
        check("rst cls_feat", cls_feat, 0);
        check("rst total", total_cnt, 0);
        check("rst pos", pos_cnt, 0);

        // All four requesting, consumer always ready: 0,1,2,3,0 every 3 cycles.
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        for (int t = 0; t < 5; t++) begin
            run_txn(t % 4, exp_cls[t % 4]);
            step();
        end
        check("rr total", total_cnt, 5);
        check("rr pos", pos_cnt, 2);
        req_valid = 4'h0;

        // Single requester 2, consumer stalls for 5 RESP cycles.
        rst = 1'b1;
        #1;
        check("rst2 total", total_cnt, 0);
        step();
        rst        = 1'b0;
        feat_tb[2] = 51'h0_0000_0000_0F0F;
        req_valid  = 4'b0100;
        rsp_ready  = 1'b0;
        #1;
        check("stall grant", req_ready, 4'b0100);
        step();
        req_valid = 4'b0000;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall valid c%0d", i), rsp_valid, 1);
            check($sformatf("stall id c%0d", i), rsp_id, 2);
            check($sformatf("stall class c%0d", i), rsp_class, 1);
            check($sformatf("stall total c%0d", i), total_cnt, 0);
            check($sformatf("stall pos c%0d", i), pos_cnt, 0);
            if (i == 4) rsp_ready = 1'b1;
            step();
        end
        check("stall done valid", rsp_valid, 0);
        check("stall done total", total_cnt, 1);
        check("stall done pos", pos_cnt, 1);
        feat_tb[2] = 51'h7_0F0F_0F0F_0F0E;

        // Reset in the middle of RESP; rr_ptr is 3 beforehand.
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        check("pre-rst grant", req_ready, 4'b1000);
        step();
        req_valid = 4'b0000;
        step();
        check("pre-rst valid", rsp_valid, 1);
        check("pre-rst id", rsp_id, 3);
        req_valid = 4'b1010;
        rst       = 1'b1;
        #1;
        check("mid-rst valid", rsp_valid, 0);
        check("mid-rst ready", req_ready, 0);
        check("mid-rst id", rsp_id, 0);
        check("mid-rst feat", cls_feat, 0);
        check("mid-rst total", total_cnt, 0);
        check("mid-rst pos", pos_cnt, 0);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        run_txn(1, exp_cls[1]);
        step();
        check("post-rst total", total_cnt, 1);

        // Non-sticky: req 1 pulsed only during EVAL of a req 0 transaction.
        req_valid = 4'b0001;
        #1;
        check("pulse grant0", req_ready, 4'b0001);
        step();
        req_valid = 4'b0010;
        #1;
        check("pulse eval ready", req_ready, 0);
        step();
        req_valid = 4'b0000;
        #1;
        check("pulse resp id", rsp_id, 0);
        check("pulse resp valid", rsp_valid, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("pulse idle valid c%0d", i), rsp_valid, 0);
            check($sformatf("pulse idle ready c%0d", i), req_ready, 0);
        end

        // Clear on a handshake with total_cnt = 7.
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'hF;
        #1;
        for (int t = 0; t < 7; t++) begin
            run_txn(t % 4, exp_cls[t % 4]);
            step();
        end
        check("pre-clr total", total_cnt, 7);
        check("pre-clr pos", pos_cnt, 3);
        run_txn(3, exp_cls[3]);
        clr_cnt = 1'b1;
        step();
        clr_cnt   = 1'b0;
        req_valid = 4'h0;
        check("clr total", total_cnt, 0);
        check("clr pos", pos_cnt, 0);

        // Saturation: 20 positive results into 4-bit counters.
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b0010;
        #1;
        for (int t = 0; t < 20; t++) begin
            run_txn(1, 1'b1);
            step();
            if (t == 9) begin
                check("sat mid total", total_cnt, 10);
                check("sat mid pos", pos_cnt, 10);
            end
        end
        check("sat total", total_cnt, 15);
        check("sat pos", pos_cnt, 15);
        req_valid = 4'h0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/class_tree_arb.md
CLASS_TREE_ARB -- requirements
Module: class_tree_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one classifier instance.
REQ-002 SHALL have parameter FEAT_W, default 51, feature-vector width, matching classifier input i.
REQ-003 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-007 SHALL have port req_feat  input  N_REQ*FEAT_W  feature vectors; requester k occupies bits [k*FEAT_W +: FEAT_W].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot grant/accept strobe.
REQ-009 SHALL have port cls_feat  output  FEAT_W  registered vector driven to shared classifier input.
REQ-010 SHALL have port cls_o  input  1  classifier output (combinational function of cls_feat).
REQ-011 SHALL have port rsp_valid  output  1  result valid.
REQ-012 SHALL have port rsp_ready  input  1  result consumer ready.
REQ-013 SHALL have port rsp_id  output  clog2(N_REQ)  index of requester owning the result.
REQ-014 SHALL have port rsp_class  output  1  captured classification.
REQ-015 SHALL have port total_cnt  output  CNT_W  completed classifications.
REQ-016 SHALL have port pos_cnt  output  CNT_W  completed classifications with rsp_class=1.
REQ-017 SHALL have port clr_cnt  input  1  synchronous clear of both counters.

Function
REQ-018 SHALL implement FSM states IDLE, EVAL, RESP.
REQ-019 IDLE: SHALL grant the first requester with req_valid=1 searching from rr_ptr upward, modulo N_REQ; no valid request -> stay IDLE, req_ready=0.
REQ-020 Grant: req_ready[k]=1 combinationally in the IDLE cycle only; on that edge SHALL latch req_feat[k] into cls_feat and k into rsp_id, then go to EVAL.
REQ-021 req_ready SHALL be all-zero in EVAL and RESP; at most one bit high in any cycle.
REQ-022 EVAL: lasts exactly one cycle; on its closing edge SHALL capture cls_o into rsp_class and go to RESP.
REQ-023 RESP: rsp_valid=1; rsp_id, rsp_class, cls_feat SHALL hold stable until rsp_valid && rsp_ready.
REQ-024 On the response handshake edge: go IDLE, rr_ptr := rsp_id+1 (wrapping N_REQ-1 -> 0), total_cnt += 1, pos_cnt += rsp_class.
REQ-025 Latency: grant at edge T -> rsp_valid high at cycle T+2; minimum issue interval 3 cycles with rsp_ready held high.
REQ-026 Requests SHALL NOT be sticky: a req_valid dropped before its grant is forgotten.
REQ-027 Counters SHALL saturate at 2^CNT_W-1, independently.
REQ-028 clr_cnt coincident with a handshake: clear SHALL win; both counters become 0.
REQ-029 rsp_valid SHALL never assert without a preceding grant; the FSM never stalls in EVAL.

Reset
REQ-030 rst asserted at any time, including mid-EVAL or mid-RESP: SHALL immediately force state=IDLE, rr_ptr=0, cls_feat=0, rsp_id=0, rsp_class=0, rsp_valid=0, req_ready=0, total_cnt=0, pos_cnt=0; any in-flight result is discarded, not counted.
REQ-031 After rst deasserts, first grant SHALL occur in the first IDLE cycle with any req_valid high.

Verification
REQ-032 All four req_valid=1 held, rsp_ready=1 -> grants in order 0,1,2,3,0 every 3 cycles; rsp_id matches grant order.
REQ-033 Only req 2 valid, feat driving cls_o=1, rsp_ready=0 for 5 cycles -> rsp_valid held 5 cycles, rsp_id=2, rsp_class=1, counters unchanged until the handshake, then total_cnt=1, pos_cnt=1.
REQ-034 CNT_W=4, 20 positive results -> total_cnt=pos_cnt=15 (saturated).
REQ-035 rst pulsed during RESP -> rsp_valid=0 within the same cycle, counters 0, next grant goes to lowest valid index from 0.
REQ-036 clr_cnt=1 on a handshake cycle with total_cnt=7 -> total_cnt=0, pos_cnt=0 next cycle.
REQ-037 req_valid[1] pulsed one cycle while FSM in EVAL -> never granted, no response for id 1.
